rx_wb_reader: RTL and testbench
===============================

Name: rx_wb_reader

Overview:
- Consumer side of the receiver sample interface: watches the sample-available strobes, drives the rd_getI / rd_getQ / rd_getWB select lines, and captures the three 16-bit words of each I/Q sample.
- Writes the words into a ping-pong sample buffer (external dual-port RAM write port) and notifies the CPU side when each half fills.
- Sits in the adc_clk domain between the receiver channel and the buffer RAM.

Parameters:
- NSAMP, 512, I/Q samples per buffer half (3 words each).
- ADDR_W, 12, buffer word address width; must satisfy 2*3*NSAMP <= 2**ADDR_W.

Ports:
- adc_clk  in  1  ADC sample clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; level.
- wb_mode  in  1  1 = wideband capture (trigger on rx_avail_wb_A), 0 = narrowband (trigger on rx_avail_A).
- rx_avail_A  in  1  narrowband sample strobe, 1 cycle.
- rx_avail_wb_A  in  1  wideband sample strobe, 1 cycle.
- rx_dout_A  in  16  receiver data word; combinational function of the select lines.
- rd_getI  out  1  select I low word.
- rd_getQ  out  1  select Q low word.
- rd_getWB  out  1  select wideband path.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  16  buffer write data.
- buf_ready  out  1  1-cycle pulse: a half has filled.
- buf_half  out  1  index of the most recently filled half.
- overrun  out  1  sticky flag: a trigger strobe arrived while busy.
- overrun_clr  in  1  clears overrun; synchronous to adc_clk.

Behaviour:
- Reset: all outputs 0. FSM enters IDLE, word counter = 0, fill half = 0, latched mode = 0.
- Trigger = wb_mode_l ? rx_avail_wb_A : rx_avail_A.
  - wb_mode_l is wb_mode registered, updated only while in IDLE.
  - enable is sampled only in IDLE.
- FSM states and transitions: IDLE -> GI -> GQ -> GH -> IDLE. Each state lasts exactly 1 cycle.
- IDLE:
  - Select lines are 0.
  - Trigger && enable moves to GI. wb_mode_l is frozen and rd_getWB = wb_mode_l for GI, GQ and GH.
- GI: rd_getI = 1. rx_dout_A is captured at the end of the cycle.
- GQ: rd_getQ = 1. Capture as in GI.
- GH: rd_getI = rd_getQ = 0, selecting the packed high-byte word. Capture as in GI.
- Select lines are registered outputs: asserted from the state-entry edge for exactly 1 cycle.
- Writes:
  - A word captured in state S appears on wr_data / wr_addr with wr_en = 1 on the cycle after S (1-cycle latency).
  - Per sample the write order is I, Q, H at consecutive addresses.
- Addressing:
  - wr_addr = fill_half*3*NSAMP + word_count.
  - word_count runs 0..3*NSAMP-1.
- Half complete:
  - On the write of word 3*NSAMP-1, buf_ready pulses in the same cycle as that wr_en.
  - buf_half = fill_half for that half. fill_half then toggles and word_count wraps to 0.
  - Writing continues uninterrupted into the other half; no CPU handshake gates capture.
- Overrun:
  - A trigger seen in GI, GQ or GH, or in the last write cycle if it coincides with a non-IDLE state, sets overrun.
  - That sample is dropped.
  - A trigger in the cycle the FSM returns to IDLE is accepted.
  - If overrun_clr and a new overrun occur in the same cycle, set wins.
- Deassertion of enable mid-sample has no effect: the current sample completes (3 words). Capture then stops. word_count and fill_half are retained.
- Rising edge of enable from a stopped state: word_count = 0, fill_half = 0.
- Reset asserted mid-sequence:
  - Immediate return to IDLE. Select lines and wr_en drop asynchronously.
  - No partial-sample completion.
- Maximum sustained rate: 1 sample per 3 cycles. A trigger spacing of less than 3 cycles guarantees overrun.

Test Plan:
- Narrowband capture: wb_mode = 0, enable = 1. Pulse rx_avail_A once; the model drives rx_dout_A = 0x1111 / 0x2222 / 0x3333 for I / Q / H selects. Required:
  - rd_getI, rd_getQ, then neither, asserted on cycles +1, +2, +3, with rd_getWB = 0.
  - Writes at addresses 0, 1, 2 with data 0x1111, 0x2222, 0x3333.
- Wideband select: wb_mode = 1, pulse rx_avail_wb_A. Required:
  - rd_getWB = 1 for all three select cycles.
  - A concurrent rx_avail_A pulse alone causes no capture.
- Half wrap: NSAMP = 4, 8 samples spaced 10 cycles apart. Required:
  - buf_ready pulses with the writes to addr 11 (buf_half = 0) and addr 23 (buf_half = 1).
  - The next sample writes addr 0.
- Overrun: triggers 2 cycles apart. Required:
  - Only the first sample is written; overrun = 1.
  - overrun_clr pulse returns it to 0.
  - A trigger exactly 3 cycles after the first is accepted without overrun.
- Enable / reset: drop enable during GQ; required: words I, Q, H are still written and later triggers are ignored. Then assert reset_n = 0 during GI of a new run; required: all outputs 0 immediately and word_count restarts at 0 after release.

Source files
------------

// File: rtl/rx_wb_reader.sv
// Purpose: pulls I, Q and packed-high words of each receiver sample into a ping-pong buffer RAM.
// Latency: selects assert 1 cycle after the trigger; each captured word is written 1 cycle after its select.
// Backpressure: none; triggers arriving while a sample is in flight are dropped and flagged as overrun.
module rx_wb_reader #(
    parameter int unsigned NSAMP  = 512,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              wb_mode,
    input  logic              rx_avail_A,
    input  logic              rx_avail_wb_A,
    input  logic [15:0]       rx_dout_A,
    output logic              rd_getI,
    output logic              rd_getQ,
    output logic              rd_getWB,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              buf_ready,
    output logic              buf_half,
    output logic              overrun,
    input  logic              overrun_clr
);

    // Words per buffer half, and the index of the last word in a half.
    localparam logic [ADDR_W-1:0] HALF_WORDS = ADDR_W'(3 * NSAMP);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(3 * NSAMP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GI   = 2'd1,
        GQ   = 2'd2,
        GH   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              wb_mode_l;
    logic              en_prev;
    logic              trig;
    logic              accept;
    logic              ovr_set;
    logic              capture;
    logic              half_done;
    logic              restart;
    logic [ADDR_W-1:0] word_count;
    logic              fill_half;
    logic              get_i_nxt;
    logic              get_q_nxt;
    logic              get_wb_nxt;

    // Trigger source follows the mode latched while idle; counters restart on an enable rising edge while idle.
    always_comb begin
        trig      = wb_mode_l ? rx_avail_wb_A : rx_avail_A;
        capture   = (state != IDLE);
        half_done = capture && (word_count == LAST_WORD);
        restart   = (state == IDLE) && enable && !en_prev;
    end

    // Next-state and next-select decode. GH is the last select cycle, so a trigger there
    // chains straight into the next sample, which sustains one sample every 3 cycles.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        ovr_set    = 1'b0;
        get_i_nxt  = 1'b0;
        get_q_nxt  = 1'b0;
        get_wb_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (trig && enable) begin
                    accept    = 1'b1;
                    state_nxt = GI;
                end
            end
            GI: begin
                ovr_set   = trig;
                state_nxt = GQ;
            end
            GQ: begin
                ovr_set   = trig;
                state_nxt = GH;
            end
            GH: begin
                if (trig && enable) begin
                    accept    = 1'b1;
                    state_nxt = GI;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        get_i_nxt  = (state_nxt == GI);
        get_q_nxt  = (state_nxt == GQ);
        get_wb_nxt = (state_nxt != IDLE) && wb_mode_l;
    end

    // State register.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Select lines are registered so they line up exactly with the state they belong to.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_getI  <= 1'b0;
            rd_getQ  <= 1'b0;
            rd_getWB <= 1'b0;
        end else begin
            rd_getI  <= get_i_nxt;
            rd_getQ  <= get_q_nxt;
            rd_getWB <= get_wb_nxt;
        end
    end

    // Mode is only tracked in idle cycles that do not start a sample, so it stays frozen for the whole sample.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_mode_l <= 1'b0;
            en_prev   <= 1'b0;
        end else begin
            en_prev <= enable;
            if ((state == IDLE) && !accept) begin
                wb_mode_l <= wb_mode;
            end
        end
    end

    // Word counter and ping-pong half pointer; a half wraps straight into the other with no handshake.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            fill_half  <= 1'b0;
        end else if (restart) begin
            word_count <= '0;
            fill_half  <= 1'b0;
        end else if (capture) begin
            if (half_done) begin
                word_count <= '0;
                fill_half  <= ~fill_half;
            end else begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    // Buffer write port: the word selected this cycle is written next cycle; buf_ready rides on the last word of a half.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            buf_ready <= 1'b0;
            buf_half  <= 1'b0;
        end else begin
            wr_en     <= capture;
            buf_ready <= half_done;
            if (capture) begin
                wr_data <= rx_dout_A;
                wr_addr <= (fill_half ? HALF_WORDS : '0) + word_count;
            end
            if (half_done) begin
                buf_half <= fill_half;
            end
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_wb_reader.sv
// Purpose: randomized and directed bench for rx_wb_reader against a timestamp-based reference model.
// Latency: model schedules selects at trigger+1..+3 and writes at trigger+2..+4.
// Backpressure: model flags triggers 1 or 2 cycles after an accepted one as overrun.
module tb_rx_wb_reader;

    localparam int NS = 4;
    localparam int AW = 5;
    localparam int HW = 3 * NS;

    logic          adc_clk;
    logic          reset_n;
    logic          enable;
    logic          wb_mode;
    logic          rx_avail_A;
    logic          rx_avail_wb_A;
    logic [15:0]   rx_dout_A;
    logic          rd_getI;
    logic          rd_getQ;
    logic          rd_getWB;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          buf_ready;
    logic          buf_half;
    logic          overrun;
    logic          overrun_clr;

    rx_wb_reader #(.NSAMP(NS), .ADDR_W(AW)) dut (
        .adc_clk       (adc_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .wb_mode       (wb_mode),
        .rx_avail_A    (rx_avail_A),
        .rx_avail_wb_A (rx_avail_wb_A),
        .rx_dout_A     (rx_dout_A),
        .rd_getI       (rd_getI),
        .rd_getQ       (rd_getQ),
        .rd_getWB      (rd_getWB),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .buf_ready     (buf_ready),
        .buf_half      (buf_half),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    // Expected activity for one cycle.
    typedef struct {
        logic          i;
        logic          q;
        logic          wb;
        logic          we;
        logic          rdy;
        logic          half;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } slot_t;

    slot_t slots [8];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_rdy  = 0;
    int    cyc    = 0;
    bit    fixed_data = 1'b1;

    // Reference model state.
    int    m_last = -100;
    int    m_idx  = 0;
    int    m_half = 0;
    bit    m_en_prev = 1'b0;
    logic  ovr_cur = 1'b0;
    logic  ovr_nxt = 1'b0;

    // Receiver data word as a function of the select lines (fixed pattern or cycle-dependent).
    function automatic logic [15:0] data_fn(input int c, input logic i, input logic q,
                                            input logic wbm, input bit fixed);
        if (fixed) begin
            if (i)      return 16'h1111;
            else if (q) return 16'h2222;
            else        return 16'h3333;
        end
        return 16'(c * 40503) ^ {wbm, i, q, 13'h0};
    endfunction

    always_comb rx_dout_A = data_fn(cyc, rd_getI, rd_getQ, rd_getWB, fixed_data);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) slots[k] = '{default: '0};
        m_last    = -100;
        m_idx     = 0;
        m_half    = 0;
        m_en_prev = 1'b0;
        ovr_nxt   = 1'b0;
    endtask

    // One cycle of the reference model: acceptance by trigger spacing, word allocation, overrun.
    task automatic model_step();
        logic trig;
        int   dt;
        trig = wb_mode ? rx_avail_wb_A : rx_avail_A;
        dt   = cyc - m_last;
        if (enable && !m_en_prev && !(dt >= 1 && dt <= 3)) begin
            m_idx  = 0;
            m_half = 0;
        end
        ovr_nxt = ovr_cur;
        if (overrun_clr) ovr_nxt = 1'b0;
        if (trig && (dt == 1 || dt == 2)) ovr_nxt = 1'b1;
        if (trig && enable && dt >= 3) begin
            m_last = cyc;
            for (int k = 0; k < 3; k++) begin
                slots[(cyc + 1 + k) % 8].i  = (k == 0);
                slots[(cyc + 1 + k) % 8].q  = (k == 1);
                slots[(cyc + 1 + k) % 8].wb = wb_mode;
                slots[(cyc + 2 + k) % 8].we   = 1'b1;
                slots[(cyc + 2 + k) % 8].addr = AW'(m_half * HW + m_idx);
                slots[(cyc + 2 + k) % 8].data = data_fn(cyc + 1 + k, k == 0, k == 1, wb_mode, fixed_data);
                slots[(cyc + 2 + k) % 8].rdy  = (m_idx == HW - 1);
                slots[(cyc + 2 + k) % 8].half = m_half[0];
                m_idx++;
                if (m_idx == HW) begin
                    m_idx  = 0;
                    m_half = 1 - m_half;
                end
            end
        end
        m_en_prev = enable;
    endtask

    // Drive one cycle of inputs, step the model, then compare outputs mid-cycle.
    task automatic cycle(input logic nb, input logic wb, input logic en, input logic clr);
        slot_t s;
        @(posedge adc_clk);
        #1;
        cyc++;
        rx_avail_A    = nb;
        rx_avail_wb_A = wb;
        enable        = en;
        overrun_clr   = clr;
        ovr_cur       = ovr_nxt;
        model_step();
        @(negedge adc_clk);
        s = slots[cyc % 8];
        chk("rd_getI", rd_getI, s.i);
        chk("rd_getQ", rd_getQ, s.q);
        chk("rd_getWB", rd_getWB, s.wb);
        chk("wr_en", wr_en, s.we);
        if (s.we) begin
            chk("wr_addr", wr_addr, s.addr);
            chk("wr_data", wr_data, s.data);
        end
        chk("buf_ready", buf_ready, s.rdy);
        if (s.rdy) chk("buf_half", buf_half, s.half);
        chk("overrun", overrun, ovr_cur);
        if (buf_ready) n_rdy++;
        slots[cyc % 8] = '{default: '0};
    endtask

    task automatic idle(input int n, input logic en);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, en, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_getI"}, rd_getI, 0);
        chk({tag, ".rd_getQ"}, rd_getQ, 0);
        chk({tag, ".rd_getWB"}, rd_getWB, 0);
        chk({tag, ".wr_en"}, wr_en, 0);
        chk({tag, ".wr_addr"}, wr_addr, 0);
        chk({tag, ".wr_data"}, wr_data, 0);
        chk({tag, ".buf_ready"}, buf_ready, 0);
        chk({tag, ".buf_half"}, buf_half, 0);
        chk({tag, ".overrun"}, overrun, 0);
    endtask

    initial begin
        reset_n       = 1'b1;
        enable        = 1'b0;
        wb_mode       = 1'b0;
        rx_avail_A    = 1'b0;
        rx_avail_wb_A = 1'b0;
        overrun_clr   = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        @(negedge adc_clk);
        chk_all_zero("reset");
        @(negedge adc_clk);
        reset_n = 1'b1;

        // Narrowband single sample with fixed I/Q/H words.
        idle(4, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Wideband: wb strobe captures with rd_getWB high; narrowband strobe alone is ignored.
        fixed_data = 1'b0;
        wb_mode = 1'b1;
        idle(6, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);
        wb_mode = 1'b0;
        idle(6, 1'b1);

        // Half wrap: restart counters via enable, 8 samples 10 cycles apart, then one more.
        idle(3, 1'b0);
        n_rdy = 0;
        for (int s = 0; s < 9; s++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            idle(9, 1'b1);
        end
        chk("ready_pulses", n_rdy, 2);

        // Overrun: spacing 2 drops the second sample; clear; spacing 3 is accepted.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("ovr_set", overrun, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("ovr_clr", overrun, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b1);
        chk("ovr_sp3", overrun, 0);
        // Set beats a simultaneous clear.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);
        chk("ovr_setwins", overrun, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset asserted during GI: outputs drop at once, addressing restarts at 0.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("gi_before_rst", rd_getI, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        repeat (2) @(posedge adc_clk);
        @(negedge adc_clk);
        reset_n = 1'b1;
        idle(3, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Enable dropped during GQ: sample completes, later triggers ignored.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Randomized traffic.
        enable = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            logic en_r;
            if (k % 150 == 0) begin
                wb_mode = ($urandom_range(0, 1) == 1);
                idle(6, enable);
            end
            en_r = enable;
            if ($urandom_range(0, 99) == 0) en_r = ~en_r;
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  en_r, ($urandom_range(0, 19) == 0));
        end
        idle(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
